// File: rtl/sti_pack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sti_pack
// Brief    : Thresholds a 128x128 8-bit image to 1 bit/pixel and packs 16
//            pixels per word into the 1024x16 binary image memory.
// Revision : 1.0 - initial release
// ============================================================================
module sti_pack #(
    parameter int THRESH     = 128,
    parameter bit BORDER_CLR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        img_rd,
    output logic [13:0] img_addr,
    input  logic [7:0]  img_di,
    output logic        sti_wr,
    output logic [9:0]  sti_addr,
    output logic [15:0] sti_do,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0]  c_S_IDLE   = 2'd0;
    localparam logic [1:0]  c_S_RUN    = 2'd1;
    localparam logic [1:0]  c_S_FLUSH  = 2'd2;
    localparam logic [1:0]  c_S_DONE   = 2'd3;
    localparam logic [13:0] c_LAST_PIX = 14'h3FFF;
    localparam logic [7:0]  c_THRESH   = 8'(THRESH);
    localparam logic [6:0]  c_EDGE     = 7'd127;

    logic [1:0]  r_state;
    logic        r_valid;
    logic [13:0] r_cap_idx;
    logic [15:0] r_word;

    logic [6:0]  w_row;
    logic [6:0]  w_col;
    logic        w_on_border;
    logic        w_bit;
    logic [15:0] w_next_word;

    assign w_row       = r_cap_idx[13:7];
    assign w_col       = r_cap_idx[6:0];
    assign w_on_border = (w_row == 7'd0) || (w_row == c_EDGE) ||
                         (w_col == 7'd0) || (w_col == c_EDGE);
    // The distance-transform engine needs a zero frame around the image.
    assign w_bit       = (img_di >= c_THRESH) && !(BORDER_CLR && w_on_border);
    assign w_next_word = {r_word[14:0], w_bit};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_S_IDLE;
            r_valid   <= 1'b0;
            r_cap_idx <= 14'd0;
            r_word    <= 16'd0;
            img_rd    <= 1'b0;
            img_addr  <= 14'd0;
            sti_wr    <= 1'b0;
            sti_addr  <= 10'd0;
            sti_do    <= 16'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Read data returns one cycle after the address, so capture lags by one.
            r_valid   <= img_rd;
            r_cap_idx <= img_addr;
            sti_wr    <= 1'b0;

            if (r_valid) begin
                r_word <= w_next_word;
                if (r_cap_idx[3:0] == 4'hF) begin
                    sti_wr   <= 1'b1;
                    sti_addr <= r_cap_idx[13:4];
                    sti_do   <= w_next_word;
                end
            end

            case (r_state)
                c_S_IDLE, c_S_DONE: begin
                    if (start) begin
                        r_state  <= c_S_RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        img_rd   <= 1'b1;
                        img_addr <= 14'd0;
                    end
                end
                c_S_RUN: begin
                    if (img_addr == c_LAST_PIX) begin
                        r_state <= c_S_FLUSH;
                        img_rd  <= 1'b0;
                    end else begin
                        img_addr <= img_addr + 14'd1;
                    end
                end
                c_S_FLUSH: begin
                    // Leave once the final capture has drained out of the pipe.
                    if (!r_valid) begin
                        r_state <= c_S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sti_pack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sti_pack
// Brief    : Self-checking bench for sti_pack, with and without border forcing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sti_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        img_rd   [2];
    logic [13:0] img_addr [2];
    logic [7:0]  img_di   [2];
    logic        sti_wr   [2];
    logic [9:0]  sti_addr [2];
    logic [15:0] sti_do   [2];
    logic        busy     [2];
    logic        done     [2];

    always #5 clk = ~clk;

    // Instance 0: border forcing off; instance 1: border forcing on.
    sti_pack #(.THRESH(128), .BORDER_CLR(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start),
        .img_rd(img_rd[0]), .img_addr(img_addr[0]), .img_di(img_di[0]),
        .sti_wr(sti_wr[0]), .sti_addr(sti_addr[0]), .sti_do(sti_do[0]),
        .busy(busy[0]), .done(done[0])
    );
    sti_pack #(.THRESH(128), .BORDER_CLR(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start),
        .img_rd(img_rd[1]), .img_addr(img_addr[1]), .img_di(img_di[1]),
        .sti_wr(sti_wr[1]), .sti_addr(sti_addr[1]), .sti_do(sti_do[1]),
        .busy(busy[1]), .done(done[1])
    );

    logic [7:0] img [16384];

    // Image memory: one-cycle read latency, garbage when not reading.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            img_di[d] <= img_rd[d] ? img[img_addr[d]] : 8'($urandom);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] exp_word(input int a, input bit bc);
        logic [15:0] w;
        int p, r, c;
        bit b;
        w = 16'd0;
        for (int k = 0; k < 16; k++) begin
            p = a * 16 + k;
            r = p / 128;
            c = p % 128;
            b = (img[p] >= 8'd128);
            if (bc && (r == 0 || r == 127 || c == 0 || c == 127)) b = 1'b0;
            w[15-k] = b;
        end
        return w;
    endfunction

    // Model: everything is a function of cycles elapsed since the accepted start.
    logic        m_act   [2] = '{1'b0, 1'b0};
    logic        m_done  [2] = '{1'b0, 1'b0};
    int          m_n     [2] = '{0, 0};
    logic [13:0] m_addr  [2] = '{14'd0, 14'd0};
    logic        m_wr    [2] = '{1'b0, 1'b0};
    logic [9:0]  m_waddr [2] = '{10'd0, 10'd0};
    logic [15:0] m_wdo   [2] = '{16'd0, 16'd0};
    int          start_e [2] = '{0, 0};
    int          ecount  = 1;

    // Observations taken from the DUT outputs.
    int          wr_cnt    [2];
    int          prev_wa   [2];
    bit          seq_ok    [2];
    int          first_rel [2];
    int          done_rel  [2];
    logic        prev_done [2] = '{1'b0, 1'b0};
    logic [15:0] smem      [2][1024];

    initial forever begin
        logic [63:0] act, exp;
        bit bc;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            exp = 64'({m_act[d] && (m_n[d] <= 16383), m_addr[d], m_wr[d], m_waddr[d],
                       m_wdo[d], m_act[d], m_done[d]});
            act = 64'({img_rd[d], img_addr[d], sti_wr[d], sti_addr[d], sti_do[d],
                       busy[d], done[d]});
            chk($sformatf("cycle_outputs_d%0d_e%0d", d, ecount), act, exp);
            if (sti_wr[d] === 1'b1) begin
                if (wr_cnt[d] == 0) first_rel[d] = ecount - start_e[d];
                else if (int'(sti_addr[d]) != prev_wa[d] + 1) seq_ok[d] = 1'b0;
                prev_wa[d] = int'(sti_addr[d]);
                wr_cnt[d]++;
                smem[d][sti_addr[d]] = sti_do[d];
            end
            if (done[d] === 1'b1 && !prev_done[d]) done_rel[d] = ecount - start_e[d];
            prev_done[d] = done[d];
        end
        ecount++;
        for (int d = 0; d < 2; d++) begin
            bc = (d == 1);
            if (!reset) begin
                m_act[d] = 1'b0; m_done[d] = 1'b0; m_n[d] = 0; m_addr[d] = 14'd0;
                m_wr[d] = 1'b0; m_waddr[d] = 10'd0; m_wdo[d] = 16'd0;
            end else begin
                if (m_act[d]) begin
                    m_n[d]++;
                    if (m_n[d] == 16386) begin m_act[d] = 1'b0; m_done[d] = 1'b1; end
                end else if (start) begin
                    m_act[d] = 1'b1; m_done[d] = 1'b0; m_n[d] = 0; start_e[d] = ecount;
                end
                m_wr[d] = 1'b0;
                if (m_act[d]) begin
                    m_addr[d] = (m_n[d] > 16383) ? 14'h3FFF : 14'(m_n[d]);
                    if (m_n[d] >= 17 && (m_n[d] - 17) % 16 == 0) begin
                        m_wr[d]    = 1'b1;
                        m_waddr[d] = 10'((m_n[d] - 17) / 16);
                        m_wdo[d]   = exp_word((m_n[d] - 17) / 16, bc);
                    end
                end
            end
        end
    end

    task automatic clr_stats();
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0; prev_wa[d] = -1; seq_ok[d] = 1'b1;
            first_rel[d] = -1; done_rel[d] = -1;
            for (int a = 0; a < 1024; a++) smem[d][a] = 16'hDEAD;
        end
    endtask

    task automatic do_start();
        @(posedge clk); #2;
        clr_stats();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (done[1] !== 1'b1 && i < 17000) begin
            @(posedge clk); #1;
            i++;
        end
        chk("frame_done_reached", 64'(done[1]), 64'd1);
        repeat (100) @(posedge clk);
        #2;
    endtask

    task automatic frame_checks();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("write_count_d%0d", d), 64'(wr_cnt[d]), 64'd1024);
            chk($sformatf("ascending_addr_d%0d", d), 64'(seq_ok[d]), 64'd1);
            chk($sformatf("first_write_edge_d%0d", d), 64'(first_rel[d]), 64'd17);
            chk($sformatf("done_edge_d%0d", d), 64'(done_rel[d]), 64'd16386);
            chk($sformatf("done_hold_d%0d", d), 64'({busy[d], done[d]}), 64'b01);
        end
    endtask

    initial begin
        bit all_ff;
        reset = 1'b0;
        start = 1'b0;
        for (int p = 0; p < 16384; p++) img[p] = 8'd0;
        clr_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({img_rd[1], img_addr[1], sti_wr[1], sti_addr[1],
                                  sti_do[1], busy[1], done[1]}), 64'd0);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Frame 1: single object pixel, threshold edge row, restart attempt at E500.
        img[5*128 + 17] = 8'd200;
        for (int c = 1; c <= 15; c++) img[128 + c] = (c % 2 == 1) ? 8'd127 : 8'd128;
        do_start();
        repeat (499) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done();
        frame_checks();
        chk("f1_word41", 64'(smem[1][41]), 64'h4000);
        chk("f1_word8",  64'(smem[1][8]),  64'h2AAA);
        chk("f1_word0",  64'(smem[1][0]),  64'h0000);
        chk("f1_word42", 64'(smem[1][42]), 64'h0000);

        // Frame 2: all pixels 0xFF.
        for (int p = 0; p < 16384; p++) img[p] = 8'hFF;
        do_start();
        wait_done();
        frame_checks();
        chk("f2_word0",    64'(smem[1][0]),    64'h0000);
        chk("f2_word7",    64'(smem[1][7]),    64'h0000);
        chk("f2_word8",    64'(smem[1][8]),    64'h7FFF);
        chk("f2_word9",    64'(smem[1][9]),    64'hFFFF);
        chk("f2_word15",   64'(smem[1][15]),   64'hFFFE);
        chk("f2_word1016", 64'(smem[1][1016]), 64'h0000);
        chk("f2_word1023", 64'(smem[1][1023]), 64'h0000);
        all_ff = 1'b1;
        for (int a = 0; a < 1024; a++) if (smem[0][a] !== 16'hFFFF) all_ff = 1'b0;
        chk("f2_noborder_all_ffff", 64'(all_ff), 64'd1);

        // Frame 3: random image, reset at E3000, then a clean re-pack.
        for (int p = 0; p < 16384; p++) img[p] = 8'($urandom);
        do_start();
        repeat (2999) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_outputs", 64'({img_rd[1], img_addr[1], sti_wr[1], sti_addr[1],
                                     sti_do[1], busy[1], done[1]}), 64'd0);
        #1 reset = 1'b1;
        repeat (60) @(posedge clk);
        #2;
        chk("writes_before_reset", 64'(wr_cnt[1]), 64'd187);
        chk("idle_after_reset", 64'({busy[1], done[1]}), 64'd0);
        do_start();
        wait_done();
        frame_checks();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
